window_addr_gen: RTL and testbench

- Upstream address generator that feeds row_group's i_ag_addr / i_ag_valid / i_row_id.
- Walks a KERNEL_SIZE x KERNEL_SIZE convolution window over a row-major input feature map stored in SRAM.
- Emits one full window of ADDR_LENGTH addresses per cycle.
- Tags each window with the destination row router, and issues windows in batches of ROUTER_COUNT, waiting for a downstream acknowledge between batches.

---
 rtl/cnn_router_pkg.sv | 26 ++
 rtl/window_scan_ctr.sv | 80 ++++++++
 rtl/window_addr_gen.sv | 214 +++++++++++++++++++++
 tb/tb_window_addr_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_router_pkg.sv
// Shared definitions for the CNN row-router address path.
// Holds the window-generator FSM state encoding, the kernel/window-length
// consistency check, and the window-address array type shared with row_group.
package cnn_router_pkg;

  localparam int unsigned KernelSize = 3;
  localparam int unsigned AddrWidth  = 8;
  localparam int unsigned AddrLength = KernelSize * KernelSize;

  // Window generator states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGen  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } ag_state_e;

  // One full window of SRAM addresses, row-major within the kernel.
  typedef logic [0:AddrLength-1][AddrWidth-1:0] win_addr_t;

  // A window carries exactly one address per kernel tap.
  function automatic bit kernel_len_ok(input int unsigned k, input int unsigned len);
    return len == k * k;
  endfunction

endpackage

// File: rtl/window_scan_ctr.sv
// Raster counter for the convolution window origin.
// Steps the column start by the stride until the window would overrun the
// map width, then wraps to column 0 and steps the row start. Holds once the
// last window origin is reached.
//   clk_i        clock
//   clr_i        synchronous active-high clear (reset or soft clear)
//   load_i       restart the scan at origin (0,0)
//   step_i       advance to the next window origin
//   stride_i     effective stride, 1..3
//   width_i      latched map width
//   height_i     latched map height
//   col_start_o  ox*S
//   row_start_o  oy*S
//   col_last_o   current origin is the last one of its row
//   last_o       current origin is the last one of the map
module window_scan_ctr
  import cnn_router_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 3
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [1:0]            stride_i,
  input  logic [ADDR_WIDTH-1:0] width_i,
  input  logic [ADDR_WIDTH-1:0] height_i,
  output logic [ADDR_WIDTH-1:0] col_start_o,
  output logic [ADDR_WIDTH-1:0] row_start_o,
  output logic                  col_last_o,
  output logic                  last_o
);

  // Wide enough that start + stride + K never overflows.
  localparam int unsigned XW = ADDR_WIDTH + 8;

  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [XW-1:0]         col_reach, row_reach;
  logic                  col_last, row_last;

  // The next origin exists only while next_start + K <= extent.
  assign col_reach = XW'(col_q) + XW'(stride_i) + XW'(KERNEL_SIZE);
  assign row_reach = XW'(row_q) + XW'(stride_i) + XW'(KERNEL_SIZE);
  assign col_last  = col_reach > XW'(width_i);
  assign row_last  = row_reach > XW'(height_i);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (!col_last) begin
        col_d = col_q + ADDR_WIDTH'(stride_i);
      end else if (!row_last) begin
        col_d = '0;
        row_d = row_q + ADDR_WIDTH'(stride_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_start_o = col_q;
  assign row_start_o = row_q;
  assign col_last_o  = col_last;
  assign last_o      = col_last & row_last;

endmodule

// File: rtl/window_addr_gen.sv
// Convolution window address generator feeding row_group.
// Walks a KxK window over a row-major feature map, emitting one full window
// of addresses per cycle, tagged with the target router index. Windows go
// out in batches of ROUTER_COUNT; between batches it waits for i_batch_ack.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_reg_clear       synchronous soft clear, same effect as i_rst
//   i_start           start a map (IDLE only)
//   i_base_addr       address of pixel (0,0)
//   i_img_width/height map dimensions W, H
//   i_stride          stride S (0 treated as 1)
//   i_batch_ack       downstream drained the batch (WAIT only)
//   o_ag_addr         window addresses, row-major within the kernel
//   o_ag_valid        window / row id valid
//   o_row_id          router index within the batch
//   o_busy            not IDLE
//   o_done            one-cycle pulse at map completion
module window_addr_gen
  import cnn_router_pkg::*;
#(
  parameter int unsigned ROUTER_COUNT = 4,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned ADDR_LENGTH  = 9
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_reg_clear,
  input  logic                                  i_start,
  input  logic [ADDR_WIDTH-1:0]                 i_base_addr,
  input  logic [ADDR_WIDTH-1:0]                 i_img_width,
  input  logic [ADDR_WIDTH-1:0]                 i_img_height,
  input  logic [1:0]                            i_stride,
  input  logic                                  i_batch_ack,
  output logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] o_ag_addr,
  output logic                                  o_ag_valid,
  output logic [ROUTER_COUNT-1:0]               o_row_id,
  output logic                                  o_busy,
  output logic                                  o_done
);

  if (!kernel_len_ok(KERNEL_SIZE, ADDR_LENGTH)) begin : g_bad_len
    $error("ADDR_LENGTH must equal KERNEL_SIZE*KERNEL_SIZE");
  end

  localparam int unsigned           XW      = ADDR_WIDTH + 8;
  localparam logic [ADDR_WIDTH-1:0] KW      = ADDR_WIDTH'(KERNEL_SIZE);
  localparam logic [ROUTER_COUNT-1:0] RidLast = ROUTER_COUNT'(ROUTER_COUNT - 1);

  logic clr;
  assign clr = i_rst | i_reg_clear;

  ag_state_e state_q, state_d;

  // Configuration captured on an accepted start.
  logic [ADDR_WIDTH-1:0] width_q, height_q;
  logic [1:0]            stride_q;
  logic                  cfg_load;

  // Address of (oy*S, 0) within the map, kept by repeated addition.
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] row_step;

  logic [ROUTER_COUNT-1:0] cnt_q, cnt_d;
  logic                    fin_q, fin_d;
  logic                    load, step;

  logic [ADDR_WIDTH-1:0] col_start, row_start;
  logic                  col_last, last;

  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0]                  row_addr;

  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                                   valid_q, valid_d;
  logic [ROUTER_COUNT-1:0]                row_id_q, row_id_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;

  window_scan_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .KERNEL_SIZE(KERNEL_SIZE)
  ) u_scan (
    .clk_i      (i_clk),
    .clr_i      (clr),
    .load_i     (load),
    .step_i     (step),
    .stride_i   (stride_q),
    .width_i    (width_q),
    .height_i   (height_q),
    .col_start_o(col_start),
    .row_start_o(row_start),
    .col_last_o (col_last),
    .last_o     (last)
  );

  // S*W as S additions of W (S is 1..3 once latched).
  always_comb begin
    row_step = width_q;
    if (stride_q >= 2'd2) row_step = row_step + width_q;
    if (stride_q == 2'd3) row_step = row_step + width_q;
  end

  always_comb begin
    row_base_d = row_base_q;
    if (cfg_load) begin
      row_base_d = i_base_addr;
    end else if (step && col_last && !last) begin
      row_base_d = row_base_q + row_step;
    end
  end

  // Kernel rows are successive +W offsets from the window row base.
  always_comb begin
    win_addr = '0;
    row_addr = row_base_q;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        win_addr[k*KERNEL_SIZE+j] = row_addr + col_start + ADDR_WIDTH'(j);
      end
      row_addr = row_addr + width_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    load     = 1'b0;
    step     = 1'b0;
    cfg_load = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    addr_d   = addr_q;
    row_id_d = row_id_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          cfg_load = 1'b1;
          load     = 1'b1;
          cnt_d    = '0;
          fin_d    = 1'b0;
          state_d  = (i_img_width < KW || i_img_height < KW) ? StDone : StGen;
        end
      end
      StGen: begin
        valid_d  = 1'b1;
        addr_d   = win_addr;
        row_id_d = cnt_q;
        step     = 1'b1;
        if (last || cnt_q == RidLast) begin
          state_d = StWait;
          cnt_d   = '0;
          fin_d   = last;
        end else begin
          cnt_d = cnt_q + ROUTER_COUNT'(1);
        end
      end
      StWait: begin
        if (i_batch_ack) state_d = fin_q ? StDone : StGen;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (clr) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      row_id_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      cnt_q      <= cnt_d;
      fin_q      <= fin_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      row_id_q   <= row_id_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (cfg_load) begin
        width_q  <= i_img_width;
        height_q <= i_img_height;
        stride_q <= (i_stride == 2'd0) ? 2'd1 : i_stride;
      end
    end
  end

  // While generating, the window origin always lies fully inside the map.
  assert property (@(posedge i_clk) disable iff (clr)
    (state_q == StGen) |->
      ((XW'(row_start) + XW'(KERNEL_SIZE) <= XW'(height_q)) &&
       (XW'(col_start) + XW'(KERNEL_SIZE) <= XW'(width_q))));

  assign o_ag_addr  = addr_q;
  assign o_ag_valid = valid_q;
  assign o_row_id   = row_id_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_window_addr_gen.sv
module tb_window_addr_gen;

  localparam int RC = 4;
  localparam int AW = 8;
  localparam int K  = 3;
  localparam int AL = 9;

  typedef logic [0:AL-1][AW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst, clr, start, ack;
  logic [AW-1:0] base, width, height;
  logic [1:0]    stride;
  win_t          ag_addr;
  logic          ag_valid;
  logic [RC-1:0] row_id;
  logic          busy, done;

  int n_vec = 0;
  int n_err = 0;
  win_t got_q[$];

  always #5 clk = ~clk;

  window_addr_gen #(
    .ROUTER_COUNT(RC),
    .ADDR_WIDTH  (AW),
    .KERNEL_SIZE (K),
    .ADDR_LENGTH (AL)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_reg_clear (clr),
    .i_start     (start),
    .i_base_addr (base),
    .i_img_width (width),
    .i_img_height(height),
    .i_stride    (stride),
    .i_batch_ack (ack),
    .o_ag_addr   (ag_addr),
    .o_ag_valid  (ag_valid),
    .o_row_id    (row_id),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one map against the reference model. abort_at >= 0 fires reset
  // (or soft clear) right after that window index is observed.
  task automatic run_map(input logic [AW-1:0] b, input logic [AW-1:0] w, input logic [AW-1:0] h,
                         input logic [1:0] s, input bit ack_in_gen, input int abort_at,
                         input bit use_clear);
    int   se, nx, ny, nwin, ox, oy, dly;
    win_t exp_w;
    se = (s == 2'd0) ? 1 : int'(s);
    nx = (int'(w) < K) ? 0 : (int'(w) - K) / se + 1;
    ny = (int'(h) < K) ? 0 : (int'(h) - K) / se + 1;
    nwin = nx * ny;
    got_q.delete();
    base = b; width = w; height = h; stride = s; start = 1'b1;
    tick();
    start = 1'b0;
    base = AW'($urandom); width = AW'($urandom); height = AW'($urandom);
    stride = 2'($urandom);
    n_vec++;
    if (busy !== 1'b1 || ag_valid !== 1'b0) begin
      n_err++;
      $display("FAIL start_latency: busy=%b valid=%b, want busy=1 valid=0", busy, ag_valid);
    end
    if (nwin == 0) begin
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL zero_early_done: done=%b want 0", done);
      end
      tick();
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || ag_valid !== 1'b0) begin
        n_err++;
        $display("FAIL zero_done: done=%b busy=%b valid=%b want 1 0 0", done, busy, ag_valid);
      end
      tick();
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL zero_done_width: done=%b want 0", done);
      end
      return;
    end
    for (int idx = 0; idx < nwin; idx++) begin
      ox = idx % nx;
      oy = idx / nx;
      for (int k = 0; k < K; k++)
        for (int j = 0; j < K; j++)
          exp_w[k*K+j] = AW'(int'(b) + (oy * se + k) * int'(w) + ox * se + j);
      ack = ack_in_gen;
      start = 1'($urandom);
      tick();
      ack = 1'b0;
      start = 1'b0;
      n_vec++;
      if (ag_valid !== 1'b1 || ag_addr !== exp_w || row_id !== RC'(idx % RC)) begin
        n_err++;
        $display("FAIL window %0d: valid=%b id=%0d addr=%h, want valid=1 id=%0d addr=%h",
                 idx, ag_valid, row_id, ag_addr, idx % RC, exp_w);
      end
      got_q.push_back(ag_addr);
      if (idx == abort_at) begin
        if (use_clear) clr = 1'b1;
        else rst = 1'b1;
        tick();
        clr = 1'b0;
        rst = 1'b0;
        n_vec++;
        if (ag_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || row_id !== '0 ||
            ag_addr !== '0) begin
          n_err++;
          $display("FAIL abort_outputs: valid=%b busy=%b done=%b id=%0d addr=%h, want all 0",
                   ag_valid, busy, done, row_id, ag_addr);
        end
        for (int c = 0; c < 4; c++) begin
          tick();
          n_vec++;
          if (done !== 1'b0 || busy !== 1'b0 || ag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: done=%b busy=%b valid=%b want 0 0 0", done, busy, ag_valid);
          end
        end
        return;
      end
      if (idx % RC == RC - 1 || idx == nwin - 1) begin
        dly = $urandom_range(0, 3);
        for (int c = 0; c <= dly; c++) begin
          tick();
          start = 1'($urandom);
          n_vec++;
          if (ag_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL wait_state: valid=%b busy=%b want 0 1", ag_valid, busy);
          end
        end
        start = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_vec++;
        if (ag_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL ack_edge: valid=%b done=%b busy=%b want 0 0 1", ag_valid, done, busy);
        end
        if (idx == nwin - 1) begin
          tick();
          n_vec++;
          if (done !== 1'b1 || busy !== 1'b0 || ag_valid !== 1'b0) begin
            n_err++;
            $display("FAIL map_done: done=%b busy=%b valid=%b want 1 0 0", done, busy, ag_valid);
          end
          tick();
          n_vec++;
          if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: done=%b want 0", done);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; start = 1'b0; ack = 1'b0;
    base = '0; width = '0; height = '0; stride = '0;
    tick();
    tick();
    rst = 1'b0;
    n_vec++;
    if (ag_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || row_id !== '0 ||
        ag_addr !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b id=%0d addr=%h, want all 0",
               ag_valid, busy, done, row_id, ag_addr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || ag_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ack: busy=%b valid=%b want 0 0", busy, ag_valid);
    end
  endtask

  task automatic test_stride1_batches();
    win_t w0, w3;
    w0 = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
    w3 = {8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12, 8'd15, 8'd16, 8'd17};
    run_map(8'd0, 8'd5, 8'd5, 2'd1, 1'b0, -1, 1'b0);
    n_vec++;
    if (got_q.size() != 9) begin
      n_err++;
      $display("FAIL s1_count: got %0d windows want 9", got_q.size());
    end else begin
      n_vec++;
      if (got_q[0] !== w0 || got_q[3] !== w3) begin
        n_err++;
        $display("FAIL s1_windows: w0=%h w3=%h want %h %h", got_q[0], got_q[3], w0, w3);
      end
    end
  endtask

  task automatic test_stride2();
    win_t w1;
    w1 = {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14};
    run_map(8'd0, 8'd5, 8'd5, 2'd2, 1'b0, -1, 1'b0);
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++;
      $display("FAIL s2_count: got %0d windows want 4", got_q.size());
    end else begin
      n_vec++;
      if (got_q[1] !== w1 || got_q[2][0] !== 8'd10) begin
        n_err++;
        $display("FAIL s2_windows: w1=%h w2[0]=%0d want %h 10", got_q[1], got_q[2][0], w1);
      end
    end
  endtask

  task automatic test_zero_windows();
    run_map(8'd0, 8'd2, 8'd5, 2'd1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_wrap_ack_in_gen();
    run_map(8'd250, 8'd5, 8'd5, 2'd1, 1'b1, -1, 1'b0);
    n_vec++;
    if (got_q.size() != 9 || got_q[0][8] !== 8'd6) begin
      n_err++;
      $display("FAIL wrap: count=%0d w0[8]=%0d want 9 6", got_q.size(), got_q[0][8]);
    end
  endtask

  task automatic test_abort(input bit use_clear);
    win_t w0;
    w0 = {8'd7, 8'd8, 8'd9, 8'd13, 8'd14, 8'd15, 8'd19, 8'd20, 8'd21};
    run_map(8'd0, 8'd5, 8'd5, 2'd1, 1'b0, 4, use_clear);
    run_map(8'd7, 8'd6, 8'd4, 2'd1, 1'b0, -1, 1'b0);
    n_vec++;
    if (got_q.size() != 8 || got_q[0] !== w0) begin
      n_err++;
      $display("FAIL restart: count=%0d w0=%h want 8 %h", got_q.size(), got_q[0], w0);
    end
  endtask

  task automatic test_stride0();
    win_t w1;
    w1 = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    run_map(8'd0, 8'd4, 8'd3, 2'd0, 1'b0, -1, 1'b0);
    n_vec++;
    if (got_q.size() != 2 || got_q[1] !== w1) begin
      n_err++;
      $display("FAIL s0: count=%0d w1=%h want 2 %h", got_q.size(), got_q[1], w1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_map(AW'($urandom), AW'($urandom_range(2, 12)), AW'($urandom_range(2, 9)),
              2'($urandom_range(0, 3)), 1'($urandom), -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_stride1_batches();
    test_stride2();
    test_zero_windows();
    test_wrap_ack_in_gen();
    test_abort(1'b0);
    test_abort(1'b1);
    test_stride0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
